e100_io_port: RTL and testbench

Bus-side I/O responder for the E100 datapath. It latches a port number and write data from the main 32-bit bus under control-unit strobes, then runs a four-phase req/ack handshake with an external device. It captures read data for `in` instructions and signals completion so the control unit can leave its wait state. It sits beside the RAM and the registers; its read-data output reaches the bus through a top-level tristate driven by the control unit.

---
 rtl/e100_io_pkg.sv | 14 +
 rtl/e100_io_port.sv | 178 +++++++++++++++++
 tb/tb_e100_io_port.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/e100_io_pkg.sv
// Shared definitions for the E100 I/O responder: FSM states and default sizes.
package e100_io_pkg;

  localparam int unsigned PORT_W_DEFAULT         = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } io_state_e;

endpackage

// File: rtl/e100_io_port.sv
// E100 bus-side I/O responder: latches port/write data from the bus and runs a
// four-phase req/ack handshake with an external device.
// Optional watchdog: define IO_TIMEOUT_EN to bound the REQ/RELEASE wait.
module e100_io_port
  import e100_io_pkg::*;
#(
  parameter int unsigned PORT_W         = PORT_W_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clock_valid,
  input  logic [31:0]       bus,
  input  logic              port_write,
  input  logic              out_write,
  input  logic              in_start,
  output logic [31:0]       io_out,
  output logic              io_busy,
  output logic              io_done,
  output logic              io_error,
  output logic [PORT_W-1:0] dev_port,
  output logic [31:0]       dev_wdata,
  output logic              dev_write,
  output logic              dev_req,
  input  logic              dev_ack,
  input  logic [31:0]       dev_rdata
);

  io_state_e         state_q, state_d;
  logic              start_c;
  logic              expire_c;
  logic              timeout_c;

  logic [31:0]       io_out_q, io_out_d;
  logic              io_busy_q, io_busy_d;
  logic              io_done_q, io_done_d;
  logic              io_error_q, io_error_d;
  logic [PORT_W-1:0] dev_port_q, dev_port_d;
  logic [31:0]       dev_wdata_q, dev_wdata_d;
  logic              dev_write_q, dev_write_d;
  logic              dev_req_q, dev_req_d;

`ifdef IO_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] cnt_inc;

  // Watchdog: counts valid cycles spent waiting in REQ/RELEASE, cleared on any state change.
  always_comb begin
    cnt_inc   = cnt_q + CntW'(1);
    cnt_d     = '0;
    timeout_c = 1'b0;
    if (state_q == REQ || state_q == RELEASE) begin
      timeout_c = (cnt_inc == CntW'(TIMEOUT_CYCLES));
      if (state_d == state_q) begin
        cnt_d = cnt_inc;
      end
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clock_valid) begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else if (clock_valid) begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an ack that arrives on the expiry cycle still counts.
  always_comb begin
    state_d  = state_q;
    start_c  = 1'b0;
    expire_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (out_write || in_start) begin
          state_d = REQ;
          start_c = 1'b1;
        end
      end
      REQ: begin
        if (dev_ack) begin
          state_d = RELEASE;
        end else if (timeout_c) begin
          state_d  = DONE;
          expire_c = 1'b1;
        end
      end
      RELEASE: begin
        if (!dev_ack) begin
          state_d = DONE;
        end else if (timeout_c) begin
          state_d  = DONE;
          expire_c = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values; port loads before a same-cycle start so the start uses it.
  always_comb begin
    io_out_d    = io_out_q;
    io_error_d  = io_error_q;
    dev_port_d  = dev_port_q;
    dev_wdata_d = dev_wdata_q;
    dev_write_d = dev_write_q;

    if (state_q == IDLE && port_write) begin
      dev_port_d = bus[PORT_W-1:0];
    end
    if (start_c) begin
      dev_write_d = out_write;
      io_error_d  = 1'b0;
      if (out_write) begin
        dev_wdata_d = bus;
      end
    end
    if (state_q == REQ && dev_ack && !dev_write_q) begin
      io_out_d = dev_rdata;
    end
    if (expire_c) begin
      io_error_d = 1'b1;
    end

    dev_req_d = (state_d == REQ);
    io_busy_d = (state_d != IDLE);
    io_done_d = (state_d == DONE);
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_out_q    <= '0;
      io_busy_q   <= 1'b0;
      io_done_q   <= 1'b0;
      io_error_q  <= 1'b0;
      dev_port_q  <= '0;
      dev_wdata_q <= '0;
      dev_write_q <= 1'b0;
      dev_req_q   <= 1'b0;
    end else if (clock_valid) begin
      io_out_q    <= io_out_d;
      io_busy_q   <= io_busy_d;
      io_done_q   <= io_done_d;
      io_error_q  <= io_error_d;
      dev_port_q  <= dev_port_d;
      dev_wdata_q <= dev_wdata_d;
      dev_write_q <= dev_write_d;
      dev_req_q   <= dev_req_d;
    end
  end

  assign io_out    = io_out_q;
  assign io_busy   = io_busy_q;
  assign io_done   = io_done_q;
  assign io_error  = io_error_q;
  assign dev_port  = dev_port_q;
  assign dev_wdata = dev_wdata_q;
  assign dev_write = dev_write_q;
  assign dev_req   = dev_req_q;

endmodule

// File: tb/tb_e100_io_port.sv
// Scoreboard bench for e100_io_port: randomized strobes and device timing,
// expectations from a transaction-level model of the port's registers.
`timescale 1ns/1ps
module tb_e100_io_port;

  logic        clock = 1'b0;
  logic        reset;
  logic        clock_valid;
  logic [31:0] bus;
  logic        port_write, out_write, in_start;
  logic [31:0] io_out;
  logic        io_busy, io_done, io_error;
  logic [7:0]  dev_port;
  logic [31:0] dev_wdata;
  logic        dev_write, dev_req;
  logic        dev_ack;
  logic [31:0] dev_rdata;

  e100_io_port #(.PORT_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .clock_valid(clock_valid), .bus(bus),
    .port_write(port_write), .out_write(out_write), .in_start(in_start),
    .io_out(io_out), .io_busy(io_busy), .io_done(io_done), .io_error(io_error),
    .dev_port(dev_port), .dev_wdata(dev_wdata), .dev_write(dev_write),
    .dev_req(dev_req), .dev_ack(dev_ack), .dev_rdata(dev_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          wr;
    logic [7:0]  port;
    logic [31:0] wdata;
    logic [31:0] io_out;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          errors  = 0;

  // Reference model of the architectural registers.
  logic [7:0]  m_port   = 8'h0;
  logic [31:0] m_wdata  = 32'h0;
  logic [31:0] m_io_out = 32'h0;
  bit          m_wr     = 1'b0;

  bit          dev_auto   = 1'b1;
  bit          cv_rand    = 1'b0;
  logic [31:0] plan_rdata = 32'h0;

  function automatic void check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // clock_valid source: always 1 unless randomization is enabled.
  initial begin
    clock_valid = 1'b1;
    forever begin
      @(negedge clock);
      clock_valid = cv_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Device model: acks after a random delay, releases after req drops.
  initial begin
    int ph  = 0;
    int cnt = 0;
    dev_ack   = 1'b0;
    dev_rdata = 32'h0;
    forever begin
      @(negedge clock);
      if (reset || !dev_auto) begin
        dev_ack = 1'b0;
        ph      = 0;
      end else begin
        case (ph)
          0: if (dev_req) begin cnt = $urandom_range(0, 3); ph = 1; end
          1: if (cnt == 0) begin dev_ack = 1'b1; dev_rdata = plan_rdata; ph = 2; end
             else cnt--;
          2: if (!dev_req) begin cnt = $urandom_range(0, 3); ph = 3; end
          default: if (cnt == 0) begin dev_ack = 1'b0; ph = 0; end
                   else cnt--;
        endcase
      end
      if (!dev_ack) dev_rdata = $urandom;
    end
  end

  // Monitor: on every valid edge, check dev_write stability and score completions.
  initial begin
    bit   cv, rs;
    exp_t e;
    forever begin
      @(posedge clock);
      cv = clock_valid;
      rs = reset;
      #1;
      if (rs || !cv) continue;
      if (dev_req) check32("dev_write_stable", 32'(dev_write), 32'(m_wr));
      if (io_done) begin
        if (sb.size() == 0) begin
          check32("unexpected_done", 32'(io_done), 32'h0);
        end else begin
          e = sb.pop_front();
          check32("done_dev_write", 32'(dev_write), 32'(e.wr));
          check32("done_dev_port",  32'(dev_port),  32'(e.port));
          check32("done_dev_wdata", dev_wdata, e.wdata);
          check32("done_io_out",    io_out,    e.io_out);
          check32("done_io_error",  32'(io_error), 32'(e.err));
        end
      end
    end
  end

  // Wait until DUT idle and all completions scored; optionally throw ignored strobes while busy.
  task automatic wait_idle(input bit junk);
    int n = 0;
    forever begin
      @(negedge clock);
      port_write = 1'b0; out_write = 1'b0; in_start = 1'b0;
      if (!io_busy && sb.size() == 0) break;
      n++;
      if (n > 400) begin
        check32("idle_timeout", 32'(sb.size()), 32'h0);
        sb.delete();
        break;
      end
      if (junk && io_busy && $urandom_range(0, 2) == 0) begin
        bus = $urandom;
        case ($urandom_range(0, 2))
          0:       port_write = 1'b1;
          1:       out_write  = 1'b1;
          default: in_start   = 1'b1;
        endcase
      end
    end
  endtask

  // Apply one strobe set in IDLE and update the model; to_exp marks an expected watchdog expiry.
  task automatic issue(input bit junk, input bit do_port, input bit do_out, input bit do_in,
                       input logic [31:0] data, input logic [31:0] rdata, input bit to_exp);
    exp_t e;
    bit   cv;
    int   n = 0;
    wait_idle(junk);
    port_write = do_port; out_write = do_out; in_start = do_in; bus = data;
    if (do_port) m_port = data[7:0];
    if (do_out || do_in) begin
      m_wr = do_out;
      if (do_out) m_wdata = data;
      else if (!to_exp) begin
        plan_rdata = rdata;
        m_io_out   = rdata;
      end
      e.wr = m_wr; e.port = m_port; e.wdata = m_wdata; e.io_out = m_io_out; e.err = to_exp;
      sb.push_back(e);
    end
    forever begin
      @(posedge clock);
      cv = clock_valid;
      #1;
      if (cv) break;
      n++;
      if (n > 50) begin
        check32("valid_edge_timeout", 32'(cv), 32'h1);
        break;
      end
    end
    check32("issue_dev_port", 32'(dev_port), 32'(m_port));
    if (do_out || do_in) begin
      check32("start_dev_req",   32'(dev_req),   32'h1);
      check32("start_io_busy",   32'(io_busy),   32'h1);
      check32("start_dev_write", 32'(dev_write), 32'(m_wr));
      check32("start_dev_wdata", dev_wdata, m_wdata);
      check32("start_io_error",  32'(io_error),  32'h0);
    end
    @(negedge clock);
    port_write = 1'b0; out_write = 1'b0; in_start = 1'b0;
  endtask

  initial begin
    int          r;
    logic [31:0] d;
    reset = 1'b1; port_write = 1'b0; out_write = 1'b0; in_start = 1'b0; bus = 32'h0;

    // Reset values.
    repeat (2) @(posedge clock);
    #1;
    check32("rst_io_out",    io_out,              32'h0);
    check32("rst_io_busy",   32'(io_busy),        32'h0);
    check32("rst_io_done",   32'(io_done),        32'h0);
    check32("rst_io_error",  32'(io_error),       32'h0);
    check32("rst_dev_port",  32'(dev_port),       32'h0);
    check32("rst_dev_wdata", dev_wdata,           32'h0);
    check32("rst_dev_write", 32'(dev_write),      32'h0);
    check32("rst_dev_req",   32'(dev_req),        32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Write to port 5, then read 0x12345678 with busy lockout strobes.
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0005, 32'h0, 1'b0);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
    issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_1111, 32'h1234_5678, 1'b0);
    wait_idle(1'b1);
    check32("read_io_out", io_out, 32'h1234_5678);

    // Simultaneous out_write and in_start: write wins.
    issue(1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFE_0001, 32'h0, 1'b0);
    wait_idle(1'b0);

    // Reset mid-handshake.
    dev_auto = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hAAAA_5555, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check32("rstreq_dev_req", 32'(dev_req),  32'h0);
    check32("rstreq_io_busy", 32'(io_busy),  32'h0);
    check32("rstreq_io_out",  io_out,        32'h0);
    check32("rstreq_port",    32'(dev_port), 32'h0);
    sb.delete();
    m_port = 8'h0; m_wdata = 32'h0; m_io_out = 32'h0; m_wr = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    dev_auto = 1'b1;
    issue(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0005, 32'h0BAD_F00D, 1'b0);
    wait_idle(1'b0);

`ifdef IO_TIMEOUT_EN
    // Watchdog: device never acks.
    begin
      int cnt = 1;
      dev_auto = 1'b0;
      issue(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0042, 32'h0, 1'b1);
      for (int i = 0; i < 100; i++) begin
        @(posedge clock);
        #1;
        if (!dev_req) break;
        cnt++;
      end
      check32("timeout_req_cycles", 32'(cnt), 32'd16);
      wait_idle(1'b0);
      check32("timeout_error_held", 32'(io_error), 32'h1);
      dev_auto = 1'b1;
    end
`endif

    // Randomized traffic with gated clock.
    cv_rand = 1'b1;
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      d = $urandom;
      if (r == 0)      issue(1'b1, 1'b1, 1'b0, 1'b0, d, 32'h0, 1'b0);
      else if (r < 5)  issue(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0, d, 32'h0, 1'b0);
      else if (r < 9)  issue(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, d, $urandom, 1'b0);
      else             issue(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1, d, 32'h0, 1'b0);
    end
    wait_idle(1'b0);
    cv_rand = 1'b0;
    repeat (2) @(negedge clock);
    check32("final_io_out",   io_out,        m_io_out);
    check32("final_dev_port", 32'(dev_port), 32'(m_port));
    check32("sb_drained",     32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
